// File: rtl/data_mem_dumper_pkg.sv
// Shared constants for the data-memory dump engine: FSM encoding, UART payload
// width and the helpers used to size counters.
package data_mem_dumper_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_LATCH   = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_WAIT_TX = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam int NB_BYTE        = 8;
  localparam int NB_DATA_DEF    = 16;
  localparam int BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE;

  function automatic int bytes_per_word(input int nb_data, input int nb_byte);
    return nb_data / nb_byte;
  endfunction

  // Counter width for n distinct values; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_mem_dumper_word_byte_serializer.sv
// Holds one captured memory word and presents it one byte at a time, most
// significant byte first.
module word_byte_serializer
  import data_mem_dumper_pkg::*;
#(
  parameter int NB_DATA = 16,
  parameter int NB_BYTE = data_mem_dumper_pkg::NB_BYTE
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_word,
  input  logic               i_advance,
  output logic [NB_BYTE-1:0] o_byte,
  output logic               o_last_byte
);

  localparam int BPW = bytes_per_word(NB_DATA, NB_BYTE);
  localparam int CW  = cnt_width(BPW);

  logic [NB_DATA-1:0] word_q, word_d;
  logic [CW-1:0]      byte_cnt_q, byte_cnt_d;

  assign o_last_byte = (byte_cnt_q == CW'(BPW - 1));

  // Loading a new word also rewinds to its top byte.
  always_comb begin
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    if (i_load) begin
      word_d     = i_word;
      byte_cnt_d = '0;
    end else if (i_advance && !o_last_byte) begin
      byte_cnt_d = byte_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      word_q     <= '0;
      byte_cnt_q <= '0;
    end else begin
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  always_comb begin
    o_byte = '0;
    for (int i = 0; i < BPW; i++) begin
      if (byte_cnt_q == CW'(i)) o_byte = word_q[NB_DATA-1-NB_BYTE*i -: NB_BYTE];
    end
  end

endmodule

// File: rtl/data_mem_dumper.sv
// Walks data memory 0..N_DATOS-1 on a start pulse and streams every word to the
// UART transmitter MSB byte first, one start/done handshake per byte.
//
// state   | meaning
// IDLE    | waiting for i_start
// RD_REQ  | read strobe on the current address
// LATCH   | registered memory data captured into the serializer
// SEND    | tx start pulse for the current byte
// WAIT_TX | holding the byte until the transmitter reports done
// DONE    | one-cycle completion pulse
module data_mem_dumper
  import data_mem_dumper_pkg::*;
#(
  parameter int NB_DATA = 16,
  parameter int NB_ADDR = 11,
  parameter int N_DATOS = 8,
  parameter int NB_BYTE = data_mem_dumper_pkg::NB_BYTE
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_mem_data,
  input  logic               i_tx_done,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic               o_mem_rd,
  output logic               o_mem_wr,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_done
);

  localparam int            AW        = cnt_width(N_DATOS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N_DATOS - 1);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          load, advance, last_byte;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          addr_d  = '0;
          state_d = ST_RD_REQ;
        end
      end
      ST_RD_REQ: state_d = ST_LATCH;
      ST_LATCH:  state_d = ST_SEND;
      ST_SEND:   state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          if (!last_byte) begin
            advance = 1'b1;
            state_d = ST_SEND;
          end else if (addr_q != LAST_ADDR) begin
            addr_d  = addr_q + AW'(1);
            state_d = ST_RD_REQ;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Memory zeros its output on idle cycles, so capture only at the end of LATCH.
  assign load = (state_q == ST_LATCH);

  word_byte_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_serializer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (load),
    .i_word      (i_mem_data),
    .i_advance   (advance),
    .o_byte      (o_tx_data),
    .o_last_byte (last_byte)
  );

  assign o_mem_addr = NB_ADDR'(addr_q);
  assign o_mem_rd   = (state_q == ST_RD_REQ);
  assign o_mem_wr   = 1'b0;
  assign o_tx_start = (state_q == ST_SEND);
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_data_mem_dumper.sv
// Scoreboard bench for data_mem_dumper: a 16-bit/8-word instance and a
// 32-bit/2-word instance, each with a registered memory model and a UART TX model.
module tb_data_mem_dumper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instance A: 16-bit words, 8 words ----------------
  logic        start_a, tx_extra_a, tx_done_m_a, tx_done_a;
  logic [15:0] mem_data_a;
  logic [10:0] addr_a;
  logic        rd_a, wr_a, txs_a, busy_a, done_a;
  logic [7:0]  txd_a;
  int          cnt_a;

  data_mem_dumper #(.NB_DATA(16), .NB_ADDR(11), .N_DATOS(8), .NB_BYTE(8)) dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_start(start_a), .i_mem_data(mem_data_a),
    .i_tx_done(tx_done_a), .o_mem_addr(addr_a), .o_mem_rd(rd_a), .o_mem_wr(wr_a),
    .o_tx_data(txd_a), .o_tx_start(txs_a), .o_busy(busy_a), .o_done(done_a));

  always @(posedge clk) mem_data_a <= rd_a ? (16'hA0B0 + {13'd0, addr_a[2:0]}) : 16'h0000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= 0; tx_done_m_a <= 1'b0;
    end else begin
      tx_done_m_a <= 1'b0;
      if (txs_a) cnt_a <= 3;
      else if (cnt_a != 0) begin
        cnt_a <= cnt_a - 1;
        if (cnt_a == 1) tx_done_m_a <= 1'b1;
      end
    end
  end
  assign tx_done_a = tx_done_m_a | tx_extra_a;

  // ---------------- instance B: 32-bit words, 2 words ----------------
  logic        start_b, tx_done_b;
  logic [31:0] mem_data_b;
  logic [10:0] addr_b;
  logic        rd_b, wr_b, txs_b, busy_b, done_b;
  logic [7:0]  txd_b;
  int          cnt_b;

  data_mem_dumper #(.NB_DATA(32), .NB_ADDR(11), .N_DATOS(2), .NB_BYTE(8)) dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_start(start_b), .i_mem_data(mem_data_b),
    .i_tx_done(tx_done_b), .o_mem_addr(addr_b), .o_mem_rd(rd_b), .o_mem_wr(wr_b),
    .o_tx_data(txd_b), .o_tx_start(txs_b), .o_busy(busy_b), .o_done(done_b));

  always @(posedge clk) mem_data_b <= rd_b ? (addr_b[0] ? 32'h55667788 : 32'h11223344) : 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_b <= 0; tx_done_b <= 1'b0;
    end else begin
      tx_done_b <= 1'b0;
      if (txs_b) cnt_b <= 3;
      else if (cnt_b != 0) begin
        cnt_b <= cnt_b - 1;
        if (cnt_b == 1) tx_done_b <= 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_byte_a[$], exp_byte_b[$];
  int         exp_addr_a[$], exp_addr_b[$];
  int         exp_done_a = 0, exp_done_b = 0;
  int         done_cnt_a = 0, done_cnt_b = 0;
  int         t0_a = 0, t0_b = 0;
  logic       done_prev_a = 1'b0, done_prev_b = 1'b0;

  // Latency from the i_start cycle to the o_done cycle:
  // 1 (to RD_REQ) + words * (2 + bytes * (1 SEND + 4 WAIT_TX)).
  localparam int LAT_A = 1 + 8 * (2 + 2 * 5);
  localparam int LAT_B = 1 + 2 * (2 + 4 * 5);

  always @(negedge clk) begin
    if (rst_n) begin
      chk("mem_wr_a", 32'(wr_a), 32'd0);
      if (rd_a) begin
        if (exp_addr_a.size() == 0) chk("rd_unexpected_a", 32'(addr_a), 32'hFFFF_FFFF);
        else chk("rd_addr_a", 32'(addr_a), 32'(exp_addr_a.pop_front()));
      end
      if (txs_a) begin
        if (exp_byte_a.size() == 0) chk("tx_unexpected_a", 32'(txd_a), 32'hFFFF_FFFF);
        else chk("tx_byte_a", 32'(txd_a), 32'(exp_byte_a.pop_front()));
      end
      if (done_prev_a) chk("busy_after_done_a", 32'(busy_a), 32'd0);
      if (done_a) begin
        chk("done_expected_a", 32'(exp_done_a), 32'd1);
        chk("done_latency_a", 32'(cyc - t0_a), 32'(LAT_A));
        exp_done_a = 0;
        done_cnt_a++;
      end
      done_prev_a = done_a;

      chk("mem_wr_b", 32'(wr_b), 32'd0);
      if (rd_b) begin
        if (exp_addr_b.size() == 0) chk("rd_unexpected_b", 32'(addr_b), 32'hFFFF_FFFF);
        else chk("rd_addr_b", 32'(addr_b), 32'(exp_addr_b.pop_front()));
      end
      if (txs_b) begin
        if (exp_byte_b.size() == 0) chk("tx_unexpected_b", 32'(txd_b), 32'hFFFF_FFFF);
        else chk("tx_byte_b", 32'(txd_b), 32'(exp_byte_b.pop_front()));
      end
      if (done_prev_b) chk("busy_after_done_b", 32'(busy_b), 32'd0);
      if (done_b) begin
        chk("done_expected_b", 32'(exp_done_b), 32'd1);
        chk("done_latency_b", 32'(cyc - t0_b), 32'(LAT_B));
        exp_done_b = 0;
        done_cnt_b++;
      end
      done_prev_b = done_b;
    end else begin
      done_prev_a = 1'b0;
      done_prev_b = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue_a();
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      exp_addr_a.push_back(k);
      exp_byte_a.push_back(8'hA0);
      exp_byte_a.push_back(8'hB0 + 8'(k));
    end
    exp_done_a = 1;
    t0_a = cyc;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a();
    int prev = done_cnt_a;
    int k = 0;
    while (done_cnt_a == prev && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) chk("timeout_done_a", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; tx_extra_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_addr_a", 32'(addr_a), 32'd0);
    chk("rst_data_a", 32'(txd_a), 32'd0);
    chk("rst_flags_a", 32'({rd_a, wr_a, txs_a, busy_a, done_a}), 32'd0);
    chk("rst_outputs_b", 32'({addr_b, txd_b, rd_b, wr_b, txs_b, busy_b, done_b}), 32'd0);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("idle_outputs_a", 32'({addr_a, txd_a, rd_a, wr_a, txs_a, busy_a, done_a}), 32'd0);
    end

    // Plain full dump.
    issue_a();
    chk("busy_after_start_a", 32'(busy_a), 32'd1);
    wait_done_a();

    // Coincident tx_done during SEND, then a restart request during WAIT_TX.
    issue_a();
    k = 0;
    while (!txs_a && k < 20) begin
      @(negedge clk);
      k++;
    end
    tx_extra_a = 1'b1;
    @(negedge clk);
    tx_extra_a = 1'b0;
    k = 1;
    while (!txs_a && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("gap_after_coincident_done_a", 32'(k), 32'd5);
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a();

    // Reset while word 3 is waiting on the transmitter.
    issue_a();
    k = 0;
    while (!(rd_a && addr_a == 11'd3) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reached_word3_a", 32'(addr_a), 32'd3);
    repeat (4) @(negedge clk);
    chk("in_wait_tx_a", 32'({busy_a, txs_a, rd_a}), 32'b100);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx_start_a", 32'(txs_a), 32'd0);
    chk("midrst_busy_a", 32'(busy_a), 32'd0);
    chk("midrst_addr_a", 32'(addr_a), 32'd0);
    exp_addr_a.delete();
    exp_byte_a.delete();
    exp_done_a = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    issue_a();
    wait_done_a();
    chk("done_count_a", 32'(done_cnt_a), 32'd3);

    // Wide-word variant.
    @(negedge clk);
    exp_addr_b.push_back(0);
    exp_addr_b.push_back(1);
    foreach (exp_byte_a[i]) chk("queue_leftover_a", 32'(exp_byte_a[i]), 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) exp_byte_b.push_back(8'h11 * 8'(i + 1));
    exp_done_b = 1;
    t0_b = cyc;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    k = 0;
    while (done_cnt_b == 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("timeout_done_b", 32'd0, 32'd1);
    repeat (2) @(negedge clk);

    chk("left_addr_a", 32'(exp_addr_a.size()), 32'd0);
    chk("left_byte_a", 32'(exp_byte_a.size()), 32'd0);
    chk("left_addr_b", 32'(exp_addr_b.size()), 32'd0);
    chk("left_byte_b", 32'(exp_byte_b.size()), 32'd0);
    chk("done_count_b", 32'(done_cnt_b), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
